rv32i_irq_source: RTL
=====================

// Module: rv32i_irq_source
// PURPOSE
//  Memory-mapped interrupt/timer source on the SoC data bus; drives the core's i_external_interrupt,
//  i_software_interrupt, i_mtime_wr/i_mtimecmp_wr and i_mtime_din/i_mtimecmp_din ports. Firmware
//  raises/clears interrupts and programs timer values; an external pin is edge-latched into a pending bit.
// PARAMETERS
//  BASE_ADDR   32'h0000_1F00  base of 32-byte register window (bits [4:0] must be 0)
//  CNT_W       16             width of saturating ack counter (1..32)
// PORTS
//  i_clk             in   1   clock, all logic on rising edge
//  i_rst             in   1   asynchronous, active-high reset
//  i_stb             in   1   bus request, one cycle per access
//  i_wr_en           in   1   1=write, 0=read
//  i_addr            in   32  byte address
//  i_wr_data         in   32  write data
//  i_wr_mask         in   4   byte enables for writes
//  o_ack             out  1   one-cycle acknowledge for an in-window access
//  o_rd_data         out  32  read data, valid while o_ack=1
//  i_ext_irq         in   1   raw external interrupt pin (asynchronous)
//  i_trap_ack        in   1   core entered trap this cycle (ce_stage5 && go_to_trap)
//  i_trap_ext        in   1   qualifies i_trap_ack: trap cause is external interrupt
//  o_external_interrupt out 1 = ext_en & ext_pend (registered)
//  o_software_interrupt out 1 = MSIP bit0 (registered)
//  o_mtime_wr        out  1   one-cycle commit strobe
//  o_mtime_din       out  64  committed mtime value
//  o_mtimecmp_wr     out  1   one-cycle commit strobe
//  o_mtimecmp_din    out  64  committed mtimecmp value
// BEHAVIOUR
//  - Reset: all outputs 0 except o_mtimecmp_din=64'hFFFF_FFFF_FFFF_FFFF; staging regs same; no strobes.
//  - Hit = i_stb && i_addr[31:5]==BASE_ADDR[31:5]. Miss: no ack, no state change.
//  - Hit -> o_ack=1 next cycle, 1 cycle wide; o_rd_data registered with it, else 0. Unmapped offsets read 0, writes ignored.
//  - Writes honour i_wr_mask per byte. Register map (byte offset):
//    0x00 MSIP      bit0 RW -> o_software_interrupt.
//    0x04 EXT_CTRL  bit0 en RW; bit1 pend RO / write-1-clears; bit2 synced pin level RO.
//    0x08 CMP_LO    RW staging low word.
//    0x0C CMP_HI    RW; accepted write updates hi staging, next cycle o_mtimecmp_din={hi,lo} and o_mtimecmp_wr=1 for exactly 1 cycle.
//    0x10 TIME_LO   RW staging; 0x14 TIME_HI same commit as CMP_HI via o_mtime_wr/o_mtime_din.
//    0x18 ACK_CNT   RO count of external-trap acks, saturates at 2^CNT_W-1; any write clears to 0.
//  - Commit uses merged (post-mask) hi word, not stale staging. Back-to-back HI writes -> back-to-back strobes.
//  - Pending: set on rising edge of synced pin (prev=0,now=1); cleared by W1C or by i_trap_ack&&i_trap_ext.
//    Set wins over simultaneous clear. Edge while pend=1: no change. pend latches even when en=0.
//  - o_external_interrupt updates the cycle after pend/en change.
//  - ACK_CNT increments on i_trap_ack&&i_trap_ext&&pend; simultaneous write-clear wins (result 0).
//  - Reset mid-operation: strobes and pending drop immediately (async), nothing committed.
// CONFIGURATION
//  IRQ_SOURCE_SYNC_EN defined: i_ext_irq through 2-flop synchronizer before edge detect; pin edge ->
//    pend=1 after 3 clocks, o_external_interrupt after 4.
//  Not defined: i_ext_irq sampled by one flop (pin must be synchronous); pend after 1, output after 2.
// TESTING
//  1 Reset: assert i_rst mid-run -> all outputs 0, o_mtimecmp_din=all-ones, no strobe on release.
//  2 Write 0x0C to CMP_LO then 0x0 to CMP_HI -> one-cycle o_mtimecmp_wr, din=64'h0000_0000_0000_000C; read back both.
//  3 EXT_CTRL en=1, pulse i_ext_irq -> pend=1, o_external_interrupt=1 at documented latency; i_trap_ack+i_trap_ext -> output 0, ACK_CNT=1.
//  4 Edge coincident with W1C of pend -> pend stays 1; edge while pend=1 -> ACK_CNT unchanged.
//  5 MSIP write 1 with mask 4'b0000 -> no change; mask 4'b0001 -> o_software_interrupt=1; write 0 -> 0.
//  6 Read 0x1C and out-of-window address -> 0 with ack / no ack; ACK_CNT saturation at 16'hFFFF.

Source files
------------

// File: rtl/rv32i_irq_source_if.sv
// Data-bus port bundle for the interrupt/timer source register window.
interface rv32i_irq_source_if;
    logic        i_stb;
    logic        i_wr_en;
    logic [31:0] i_addr;
    logic [31:0] i_wr_data;
    logic [3:0]  i_wr_mask;
    logic        o_ack;
    logic [31:0] o_rd_data;

    modport master (
        output i_stb, i_wr_en, i_addr, i_wr_data, i_wr_mask,
        input  o_ack, o_rd_data
    );

    modport slave (
        input  i_stb, i_wr_en, i_addr, i_wr_data, i_wr_mask,
        output o_ack, o_rd_data
    );
endinterface

// File: rtl/rv32i_irq_source.sv
// Memory-mapped interrupt/timer source: MSIP, edge-latched external IRQ, mtime/mtimecmp commit, trap-ack counter.
// Optional IRQ_SOURCE_SYNC_EN adds a 2-flop synchronizer in front of the external pin edge detector.
module rv32i_irq_source #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1F00,
    parameter int          CNT_W     = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    rv32i_irq_source_if.slave   bus,
    input  logic                i_ext_irq,
    input  logic                i_trap_ack,
    input  logic                i_trap_ext,
    output logic                o_external_interrupt,
    output logic                o_software_interrupt,
    output logic                o_mtime_wr,
    output logic [63:0]         o_mtime_din,
    output logic                o_mtimecmp_wr,
    output logic [63:0]         o_mtimecmp_din
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             ack_q, ack_d;
    logic [31:0]      rd_q, rd_d;
    logic             msip_q, msip_d;
    logic             en_q, en_d;
    logic             pend_q, pend_d;
    logic             ext_irq_q, ext_irq_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      cmp_lo_q, cmp_lo_d, cmp_hi_q, cmp_hi_d;
    logic [31:0]      time_lo_q, time_lo_d, time_hi_q, time_hi_d;
    logic             cmp_wr_q, cmp_wr_d, time_wr_q, time_wr_d;
    logic [63:0]      cmp_din_q, cmp_din_d, time_din_q, time_din_d;
    logic             lvl_prev_q;
    logic             pin_lvl;
    logic             pin_rise;

    logic       hit, wr_hit, rd_hit, w1c, cnt_clr, trap_ext;
    logic [2:0] offs;
    logic       unused_addr;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (mask[b]) r[8*b +: 8] = wdata[8*b +: 8];
        return r;
    endfunction

`ifdef IRQ_SOURCE_SYNC_EN
    logic sync1_q, sync2_q;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= i_ext_irq;
            sync2_q <= sync1_q;
        end
    end
    assign pin_lvl = sync2_q;
`else
    // Pin is assumed synchronous to i_clk; lvl_prev_q is the single sampling flop.
    assign pin_lvl = i_ext_irq;
`endif

    assign pin_rise = pin_lvl & ~lvl_prev_q;

    assign hit         = bus.i_stb && (bus.i_addr[31:5] == BASE_ADDR[31:5]);
    assign wr_hit      = hit && bus.i_wr_en;
    assign rd_hit      = hit && !bus.i_wr_en;
    assign offs        = bus.i_addr[4:2];
    assign unused_addr = ^bus.i_addr[1:0];
    assign trap_ext    = i_trap_ack && i_trap_ext;
    assign w1c         = wr_hit && (offs == 3'd1) && bus.i_wr_mask[0] && bus.i_wr_data[1];
    assign cnt_clr     = wr_hit && (offs == 3'd6);

    always_comb begin
        ack_d      = hit;
        rd_d       = '0;
        msip_d     = msip_q;
        en_d       = en_q;
        pend_d     = pend_q;
        ext_irq_d  = en_q & pend_q;
        cnt_d      = cnt_q;
        cmp_lo_d   = cmp_lo_q;
        cmp_hi_d   = cmp_hi_q;
        time_lo_d  = time_lo_q;
        time_hi_d  = time_hi_q;
        cmp_wr_d   = 1'b0;
        time_wr_d  = 1'b0;
        cmp_din_d  = cmp_din_q;
        time_din_d = time_din_q;

        if (wr_hit) begin
            case (offs)
                3'd0: if (bus.i_wr_mask[0]) msip_d = bus.i_wr_data[0];
                3'd1: if (bus.i_wr_mask[0]) en_d = bus.i_wr_data[0];
                3'd2: cmp_lo_d = merge(cmp_lo_q, bus.i_wr_data, bus.i_wr_mask);
                3'd3: begin
                    // Commit uses the merged hi word so the strobe never carries stale staging.
                    cmp_hi_d  = merge(cmp_hi_q, bus.i_wr_data, bus.i_wr_mask);
                    cmp_din_d = {cmp_hi_d, cmp_lo_q};
                    cmp_wr_d  = 1'b1;
                end
                3'd4: time_lo_d = merge(time_lo_q, bus.i_wr_data, bus.i_wr_mask);
                3'd5: begin
                    time_hi_d  = merge(time_hi_q, bus.i_wr_data, bus.i_wr_mask);
                    time_din_d = {time_hi_d, time_lo_q};
                    time_wr_d  = 1'b1;
                end
                default: ;
            endcase
        end

        if (rd_hit) begin
            case (offs)
                3'd0:    rd_d = {31'd0, msip_q};
                3'd1:    rd_d = {29'd0, pin_lvl, pend_q, en_q};
                3'd2:    rd_d = cmp_lo_q;
                3'd3:    rd_d = cmp_hi_q;
                3'd4:    rd_d = time_lo_q;
                3'd5:    rd_d = time_hi_q;
                3'd6:    rd_d = 32'(cnt_q);
                default: rd_d = '0;
            endcase
        end

        // A new edge takes priority over any clear arriving in the same cycle.
        if (pin_rise)
            pend_d = 1'b1;
        else if (w1c || trap_ext)
            pend_d = 1'b0;

        if (cnt_clr)
            cnt_d = '0;
        else if (trap_ext && pend_q && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ack_q      <= 1'b0;
            rd_q       <= '0;
            msip_q     <= 1'b0;
            en_q       <= 1'b0;
            pend_q     <= 1'b0;
            ext_irq_q  <= 1'b0;
            cnt_q      <= '0;
            cmp_lo_q   <= '1;
            cmp_hi_q   <= '1;
            time_lo_q  <= '0;
            time_hi_q  <= '0;
            cmp_wr_q   <= 1'b0;
            time_wr_q  <= 1'b0;
            cmp_din_q  <= '1;
            time_din_q <= '0;
            lvl_prev_q <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            rd_q       <= rd_d;
            msip_q     <= msip_d;
            en_q       <= en_d;
            pend_q     <= pend_d;
            ext_irq_q  <= ext_irq_d;
            cnt_q      <= cnt_d;
            cmp_lo_q   <= cmp_lo_d;
            cmp_hi_q   <= cmp_hi_d;
            time_lo_q  <= time_lo_d;
            time_hi_q  <= time_hi_d;
            cmp_wr_q   <= cmp_wr_d;
            time_wr_q  <= time_wr_d;
            cmp_din_q  <= cmp_din_d;
            time_din_q <= time_din_d;
            lvl_prev_q <= pin_lvl;
        end
    end

    assign bus.o_ack            = ack_q;
    assign bus.o_rd_data        = rd_q;
    assign o_software_interrupt = msip_q;
    assign o_external_interrupt = ext_irq_q;
    assign o_mtimecmp_wr        = cmp_wr_q;
    assign o_mtimecmp_din       = cmp_din_q;
    assign o_mtime_wr           = time_wr_q;
    assign o_mtime_din          = time_din_q;

endmodule
